// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared constants and types for the dual-channel multiplier scheduler
//
// Contents:
//   WIDTH / PWIDTH  operand width and full product width
//   ch_t            channel id (CH_A, CH_B)
//   tag_t           per-issue tag {valid, ch} carried alongside the multiplier pipeline
package mult_sched_pkg;

    localparam int WIDTH  = 64;
    localparam int PWIDTH = 2 * WIDTH;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

    typedef struct packed {
        logic valid;
        ch_t  ch;
    } tag_t;

endpackage

// File: rtl/mult_result_fifo.sv
// rtl/mult_result_fifo.sv - first-word-fall-through result FIFO with occupancy count
//
// Ports:
//   clk_in, rst_n       clock, asynchronous active-low reset
//   i_wr_en, i_wr_data  push one product (caller guarantees the FIFO is not full)
//   o_valid, i_ready    head entry valid / consumed; pop on o_valid & i_ready
//   o_data              head entry, zero while empty
//   o_count             registered occupancy, 0..FIFO_DEPTH
module mult_result_fifo #(
    parameter int PWIDTH     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n,
    input  logic                            i_wr_en,
    input  logic [PWIDTH-1:0]               i_wr_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [PWIDTH-1:0]               o_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [PWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;

    assign w_pop   = (r_count != '0) && i_ready;
    assign o_valid = (r_count != '0);
    // Gate the head so the output reads zero while empty, including in reset.
    assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_wr_en && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_wr_en && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mult_dual_sched.sv
// rtl/mult_dual_sched.sv - round-robin scheduler sharing one pipelined multiplier between two channels
//
// Ports:
//   clk_in, rst_n                    clock, asynchronous active-low reset
//   a_valid/a_ready, a_x/a_y         channel A operand handshake and operands
//   a_p_valid/a_p_ready, a_p         channel A result handshake and product
//   b_*                              same for channel B
//   mul_x/mul_y, mul_clk_en, mul_p   interface to the external MUL_LAT-cycle multiplier
//   busy                             any product in flight or buffered
module mult_dual_sched #(
    parameter int WIDTH      = mult_sched_pkg::WIDTH,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [WIDTH-1:0]     a_x,
    input  logic [WIDTH-1:0]     a_y,
    output logic                 a_p_valid,
    input  logic                 a_p_ready,
    output logic [2*WIDTH-1:0]   a_p,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [WIDTH-1:0]     b_x,
    input  logic [WIDTH-1:0]     b_y,
    output logic                 b_p_valid,
    input  logic                 b_p_ready,
    output logic [2*WIDTH-1:0]   b_p,
    output logic [WIDTH-1:0]     mul_x,
    output logic [WIDTH-1:0]     mul_y,
    output logic                 mul_clk_en,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy
);

    import mult_sched_pkg::*;

    localparam int PW  = 2 * WIDTH;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int IW  = $clog2(MUL_LAT + 1);
    localparam int SW  = ((FCW > IW) ? FCW : IW) + 1;

    logic           r_run;
    ch_t            r_last_grant;
    tag_t           r_tag [MUL_LAT];
    logic [IW-1:0]  r_inflight_a;
    logic [IW-1:0]  r_inflight_b;

    logic [FCW-1:0] w_count_a;
    logic [FCW-1:0] w_count_b;
    logic [SW-1:0]  w_used_a;
    logic [SW-1:0]  w_used_b;
    logic           w_elig_a;
    logic           w_elig_b;
    logic           w_grant_a;
    logic           w_grant_b;
    logic           w_grant_any;
    ch_t            w_grant_ch;
    logic           w_ret_a;
    logic           w_ret_b;
    logic           w_tags_busy;

    // Credit is judged only from registered counts, so nothing on the result
    // side (X_p_ready) reaches X_ready combinationally.
    assign w_used_a = SW'(w_count_a) + SW'(r_inflight_a);
    assign w_used_b = SW'(w_count_b) + SW'(r_inflight_b);

    // r_run holds off all grants until the first edge after reset release.
    assign w_elig_a = r_run && a_valid && (w_used_a < SW'(FIFO_DEPTH));
    assign w_elig_b = r_run && b_valid && (w_used_b < SW'(FIFO_DEPTH));

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_elig_a && w_elig_b) begin
            if (r_last_grant == CH_A) begin
                w_grant_b = 1'b1;
            end else begin
                w_grant_a = 1'b1;
            end
        end else begin
            w_grant_a = w_elig_a;
            w_grant_b = w_elig_b;
        end
    end

    assign w_grant_any = w_grant_a || w_grant_b;
    assign w_grant_ch  = w_grant_b ? CH_B : CH_A;

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign mul_x      = w_grant_a ? a_x : (w_grant_b ? b_x : '0);
    assign mul_y      = w_grant_a ? a_y : (w_grant_b ? b_y : '0);
    assign mul_clk_en = r_run;

    // The tag leaving the pipe lines up with mul_p for the same issue.
    assign w_ret_a = r_tag[MUL_LAT-1].valid && (r_tag[MUL_LAT-1].ch == CH_A);
    assign w_ret_b = r_tag[MUL_LAT-1].valid && (r_tag[MUL_LAT-1].ch == CH_B);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_last_grant <= CH_B;
            r_inflight_a <= '0;
            r_inflight_b <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (w_grant_any) begin
                r_last_grant <= w_grant_ch;
            end
            r_tag[0] <= tag_t'{valid: w_grant_any, ch: w_grant_ch};
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_grant_a && !w_ret_a) begin
                r_inflight_a <= r_inflight_a + IW'(1);
            end else if (!w_grant_a && w_ret_a) begin
                r_inflight_a <= r_inflight_a - IW'(1);
            end
            if (w_grant_b && !w_ret_b) begin
                r_inflight_b <= r_inflight_b + IW'(1);
            end else if (!w_grant_b && w_ret_b) begin
                r_inflight_b <= r_inflight_b - IW'(1);
            end
        end
    end

    always_comb begin
        w_tags_busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            w_tags_busy = w_tags_busy | r_tag[i].valid;
        end
    end

    assign busy = w_tags_busy || (w_count_a != '0) || (w_count_b != '0);

    mult_result_fifo #(
        .PWIDTH     (PW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_wr_en   (w_ret_a),
        .i_wr_data (mul_p),
        .o_valid   (a_p_valid),
        .i_ready   (a_p_ready),
        .o_data    (a_p),
        .o_count   (w_count_a)
    );

    mult_result_fifo #(
        .PWIDTH     (PW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_wr_en   (w_ret_b),
        .i_wr_data (mul_p),
        .o_valid   (b_p_valid),
        .i_ready   (b_p_ready),
        .o_data    (b_p),
        .o_count   (w_count_b)
    );

endmodule

// File: tb/tb_mult_dual_sched.sv
// tb/tb_mult_dual_sched.sv - self-checking bench for mult_dual_sched
module tb_mult_dual_sched;

    localparam int WIDTH      = 64;
    localparam int MUL_LAT    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PW         = 2 * WIDTH;

    localparam logic [PW-1:0] A_SQ_REF = 128'hFFFFFFFFFFFFFFFE_0000000000000001;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             a_valid, a_ready, a_p_valid, a_p_ready;
    logic             b_valid, b_ready, b_p_valid, b_p_ready;
    logic [WIDTH-1:0] a_x, a_y, b_x, b_y, mul_x, mul_y;
    logic [PW-1:0]    a_p, b_p, mul_p;
    logic             mul_clk_en, busy;

    int               n_assert = 0;
    int               n_fail   = 0;

    logic [PW-1:0]    qa[$];
    logic [PW-1:0]    qb[$];
    logic [PW-1:0]    last_a_p = '0;
    logic [PW-1:0]    last_b_p = '0;
    int               max_qa   = 0;
    logic [PW-1:0]    mpipe [MUL_LAT];
    logic [PW-1:0]    b_ref;

    always #5 clk_in = ~clk_in;

    mult_dual_sched #(
        .WIDTH      (WIDTH),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_x        (a_x),
        .a_y        (a_y),
        .a_p_valid  (a_p_valid),
        .a_p_ready  (a_p_ready),
        .a_p        (a_p),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_x        (b_x),
        .b_y        (b_y),
        .b_p_valid  (b_p_valid),
        .b_p_ready  (b_p_ready),
        .b_p        (b_p),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_clk_en (mul_clk_en),
        .mul_p      (mul_p),
        .busy       (busy)
    );

    // External multiplier: MUL_LAT register stages, frozen while disabled.
    always @(posedge clk_in) begin
        if (mul_clk_en) begin
            mpipe[0] <= {{WIDTH{1'b0}}, mul_x} * {{WIDTH{1'b0}}, mul_y};
            for (int i = 1; i < MUL_LAT; i++) begin
                mpipe[i] <= mpipe[i-1];
            end
        end
    end
    assign mul_p = mpipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk_in);
        #1;
    endtask

    // Scoreboard: accepted operands produce expected products; results must
    // pop in issue order per channel.
    always @(negedge clk_in) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            check("ready_exclusive", PW'(a_ready & b_ready), '0);
            if (a_p_valid && a_p_ready) begin
                if (qa.size() == 0) begin
                    check("a_p_unexpected", PW'(a_p_valid), '0);
                end else begin
                    check("a_p_order", a_p, qa.pop_front());
                    last_a_p = a_p;
                end
            end
            if (b_p_valid && b_p_ready) begin
                if (qb.size() == 0) begin
                    check("b_p_unexpected", PW'(b_p_valid), '0);
                end else begin
                    check("b_p_order", b_p, qb.pop_front());
                    last_b_p = b_p;
                end
            end
            if (a_valid && a_ready) qa.push_back({{WIDTH{1'b0}}, a_x} * {{WIDTH{1'b0}}, a_y});
            if (b_valid && b_ready) qb.push_back({{WIDTH{1'b0}}, b_x} * {{WIDTH{1'b0}}, b_y});
            if (qa.size() > max_qa) max_qa = qa.size();
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            at_sample();
            if (!busy) break;
            next_cycle();
        end
        check("idle_timeout", PW'(busy), '0);
        next_cycle();
    endtask

    initial begin
        int lat;
        int n_a;
        int n_b_tail;
        logic [1:0] exp_grant;

        b_ref = {{WIDTH{1'b0}}, 64'd8563214857120369541} * {{WIDTH{1'b0}}, 64'd6579858412322574896};

        // Reset with both requesters active.
        rst_n = 1'b0;
        a_valid = 1'b1; a_x = 64'd1; a_y = 64'd1;
        b_valid = 1'b1; b_x = 64'd2; b_y = 64'd2;
        a_p_ready = 1'b1; b_p_ready = 1'b1;
        next_cycle(); next_cycle();
        at_sample();
        check("rst_ready", PW'({a_ready, b_ready}), '0);
        check("rst_p_valid", PW'({a_p_valid, b_p_valid}), '0);
        check("rst_p", a_p | b_p, '0);
        check("rst_mul_xy", {mul_x, mul_y}, '0);
        check("rst_clk_en_busy", PW'({mul_clk_en, busy}), '0);

        next_cycle();
        rst_n = 1'b1;
        at_sample();
        check("release_no_grant", PW'({mul_clk_en, a_ready, b_ready}), '0);
        next_cycle();
        at_sample();
        check("first_grant_a", PW'({mul_clk_en, a_ready, b_ready}), PW'(3'b110));
        next_cycle();
        at_sample();
        check("second_grant_b", PW'({a_ready, b_ready}), PW'(2'b01));
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle();

        // Single A: 3 x 5, latency and busy.
        a_valid = 1'b1; a_x = 64'd3; a_y = 64'd5;
        at_sample();
        check("single_accept", PW'(a_ready), PW'(1'b1));
        next_cycle();
        a_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            at_sample();
            if (a_p_valid) begin
                lat = k;
                break;
            end
            check("single_busy", PW'(busy), PW'(1'b1));
            check("single_b_quiet", PW'(b_p_valid), '0);
            next_cycle();
        end
        check("single_latency", PW'(lat), PW'(MUL_LAT + 1));
        check("single_a_p", a_p, PW'(15));
        next_cycle();
        wait_idle();

        // Contention: last grant was A, so B leads and grants alternate.
        a_valid = 1'b1; a_x = '1; a_y = '1;
        b_valid = 1'b1; b_x = 64'd8563214857120369541; b_y = 64'd6579858412322574896;
        exp_grant = 2'b01;
        for (int k = 0; k < 8; k++) begin
            at_sample();
            check("contention_alternate", PW'({a_ready, b_ready}), PW'(exp_grant));
            exp_grant = ~exp_grant;
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle();
        check("a_square_max", last_a_p, A_SQ_REF);
        check("b_big_product", last_b_p, b_ref);

        // Backpressure on A; B keeps draining.
        a_p_ready = 1'b0;
        n_a = 0;
        n_b_tail = 0;
        for (int k = 0; k < 30; k++) begin
            a_valid = 1'b1; a_x = 64'(100 + k); a_y = 64'd7;
            b_valid = 1'b1; b_x = 64'(200 + k); b_y = 64'd3;
            at_sample();
            if (a_ready) n_a++;
            if (k >= 20 && b_ready) n_b_tail++;
            next_cycle();
        end
        check("bp_a_accepts", PW'(n_a), PW'(FIFO_DEPTH));
        check("bp_b_full_rate", PW'(n_b_tail), PW'(10));

        // Credit release from one pop appears the cycle after the pop.
        b_valid = 1'b0;
        at_sample();
        check("credit_blocked", PW'(a_ready), '0);
        next_cycle();
        a_p_ready = 1'b1;
        at_sample();
        check("credit_pop_same_cycle", PW'({a_p_valid, a_ready}), PW'(2'b10));
        next_cycle();
        a_p_ready = 1'b0;
        at_sample();
        check("credit_next_cycle", PW'(a_ready), PW'(1'b1));
        next_cycle();
        a_valid = 1'b0; a_p_ready = 1'b1;
        wait_idle();
        check("a_occupancy_bound", PW'(max_qa <= FIFO_DEPTH), PW'(1'b1));

        // Mid-flight reset after three issues.
        a_valid = 1'b1; a_x = 64'd9; a_y = 64'd9;
        for (int k = 0; k < 3; k++) begin
            at_sample();
            check("midrst_issue", PW'(a_ready), PW'(1'b1));
            next_cycle();
        end
        a_valid = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        next_cycle(); next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < MUL_LAT + 4; k++) begin
            at_sample();
            check("midrst_quiet", PW'({a_p_valid, b_p_valid, busy}), '0);
            next_cycle();
        end

        // Normal operation resumes after the mid-flight reset.
        a_valid = 1'b1; a_x = 64'd6; a_y = 64'd7;
        at_sample();
        check("post_rst_accept", PW'(a_ready), PW'(1'b1));
        next_cycle();
        a_valid = 1'b0;
        wait_idle();
        check("post_rst_a_p", last_a_p, PW'(42));
        check("sb_empty", PW'(qa.size() + qb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
